// File: rtl/car_pkg.sv
// Shared constants for the MSP430 microsequencer: CAR encodings, register indices, opcode fields.
// Each multi-step sequence occupies consecutive codes so that non-terminal steps advance by +1.
package car_pkg;

  localparam int unsigned CAR_BITS = 6;

  localparam logic [CAR_BITS-1:0] CAR_0          = 6'd0;
  localparam logic [CAR_BITS-1:0] CAR_REG_REG    = 6'd1;
  localparam logic [CAR_BITS-1:0] CAR_REG_IDX0   = 6'd2;
  localparam logic [CAR_BITS-1:0] CAR_REG_IDX1   = 6'd3;
  localparam logic [CAR_BITS-1:0] CAR_REG_IDX2   = 6'd4;
  localparam logic [CAR_BITS-1:0] CAR_REG_IDX3   = 6'd5;
  localparam logic [CAR_BITS-1:0] CAR_IND_REG0   = 6'd6;
  localparam logic [CAR_BITS-1:0] CAR_IND_REG1   = 6'd7;
  localparam logic [CAR_BITS-1:0] CAR_IND_IDX0   = 6'd8;
  localparam logic [CAR_BITS-1:0] CAR_IND_IDX1   = 6'd9;
  localparam logic [CAR_BITS-1:0] CAR_IND_IDX2   = 6'd10;
  localparam logic [CAR_BITS-1:0] CAR_IND_IDX3   = 6'd11;
  localparam logic [CAR_BITS-1:0] CAR_IND_IDX4   = 6'd12;
  localparam logic [CAR_BITS-1:0] CAR_IDX_REG0   = 6'd13;
  localparam logic [CAR_BITS-1:0] CAR_IDX_REG1   = 6'd14;
  localparam logic [CAR_BITS-1:0] CAR_IDX_REG2   = 6'd15;
  localparam logic [CAR_BITS-1:0] CAR_IDX_IDX0   = 6'd16;
  localparam logic [CAR_BITS-1:0] CAR_IDX_IDX1   = 6'd17;
  localparam logic [CAR_BITS-1:0] CAR_IDX_IDX2   = 6'd18;
  localparam logic [CAR_BITS-1:0] CAR_IDX_IDX3   = 6'd19;
  localparam logic [CAR_BITS-1:0] CAR_IDX_IDX4   = 6'd20;
  localparam logic [CAR_BITS-1:0] CAR_IDX_IDX5   = 6'd21;
  localparam logic [CAR_BITS-1:0] CAR_1OP_REG    = 6'd22;
  localparam logic [CAR_BITS-1:0] CAR_1OP_IND0   = 6'd23;
  localparam logic [CAR_BITS-1:0] CAR_1OP_IND1   = 6'd24;
  localparam logic [CAR_BITS-1:0] CAR_1OP_IND2   = 6'd25;
  localparam logic [CAR_BITS-1:0] CAR_1OP_IDX0   = 6'd26;
  localparam logic [CAR_BITS-1:0] CAR_1OP_IDX1   = 6'd27;
  localparam logic [CAR_BITS-1:0] CAR_1OP_IDX2   = 6'd28;
  localparam logic [CAR_BITS-1:0] CAR_1OP_IDX3   = 6'd29;
  localparam logic [CAR_BITS-1:0] CAR_PUSH_REG0  = 6'd30;
  localparam logic [CAR_BITS-1:0] CAR_PUSH_REG1  = 6'd31;
  localparam logic [CAR_BITS-1:0] CAR_PUSH_REG2  = 6'd32;
  localparam logic [CAR_BITS-1:0] CAR_PUSH_IND0  = 6'd33;
  localparam logic [CAR_BITS-1:0] CAR_PUSH_IND1  = 6'd34;
  localparam logic [CAR_BITS-1:0] CAR_PUSH_IND2  = 6'd35;
  localparam logic [CAR_BITS-1:0] CAR_PUSH_IDX0  = 6'd36;
  localparam logic [CAR_BITS-1:0] CAR_PUSH_IDX1  = 6'd37;
  localparam logic [CAR_BITS-1:0] CAR_PUSH_IDX2  = 6'd38;
  localparam logic [CAR_BITS-1:0] CAR_PUSH_IDX3  = 6'd39;
  localparam logic [CAR_BITS-1:0] CAR_CALL_REG0  = 6'd40;
  localparam logic [CAR_BITS-1:0] CAR_CALL_REG1  = 6'd41;
  localparam logic [CAR_BITS-1:0] CAR_CALL_REG2  = 6'd42;
  localparam logic [CAR_BITS-1:0] CAR_CALL_IND0  = 6'd43;
  localparam logic [CAR_BITS-1:0] CAR_CALL_IND1  = 6'd44;
  localparam logic [CAR_BITS-1:0] CAR_CALL_IND2  = 6'd45;
  localparam logic [CAR_BITS-1:0] CAR_CALL_IDX0  = 6'd46;
  localparam logic [CAR_BITS-1:0] CAR_CALL_IDX1  = 6'd47;
  localparam logic [CAR_BITS-1:0] CAR_CALL_IDX2  = 6'd48;
  localparam logic [CAR_BITS-1:0] CAR_CALL_IDX3  = 6'd49;
  localparam logic [CAR_BITS-1:0] CAR_RETI0      = 6'd50;
  localparam logic [CAR_BITS-1:0] CAR_RETI1      = 6'd51;
  localparam logic [CAR_BITS-1:0] CAR_RETI2      = 6'd52;
  localparam logic [CAR_BITS-1:0] CAR_RETI3      = 6'd53;
  localparam logic [CAR_BITS-1:0] CAR_JMP0       = 6'd54;
  localparam logic [CAR_BITS-1:0] CAR_INT0       = 6'd55;
  localparam logic [CAR_BITS-1:0] CAR_INT1       = 6'd56;
  localparam logic [CAR_BITS-1:0] CAR_INT2       = 6'd57;
  localparam logic [CAR_BITS-1:0] CAR_INT3       = 6'd58;
  localparam logic [CAR_BITS-1:0] CAR_INT4       = 6'd59;
  localparam logic [CAR_BITS-1:0] CAR_LAST       = CAR_INT4;

  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SP = 4'd1;
  localparam logic [3:0] REG_SR = 4'd2;
  localparam logic [3:0] REG_CG = 4'd3;

  localparam logic [5:0] F2_PREFIX  = 6'b000100;
  localparam logic [2:0] JMP_PREFIX = 3'b001;
  localparam logic [2:0] OP_PUSH    = 3'b100;
  localparam logic [2:0] OP_CALL    = 3'b101;
  localparam logic [2:0] OP_RETI    = 3'b110;

  typedef enum logic [1:0] {ClsReg, ClsIdx, ClsInd} src_cls_e;

  function automatic src_cls_e as_class(input logic [1:0] as_mode);
    if (as_mode == 2'b00) return ClsReg;
    if (as_mode == 2'b01) return ClsIdx;
    return ClsInd;
  endfunction

  // R3 always and R2 in indirect modes are constant generators, so they behave like a register.
  function automatic src_cls_e src_class(input logic [3:0] src, input logic [1:0] as_mode);
    if (src == REG_CG || (src == REG_SR && as_mode[1])) return ClsReg;
    return as_class(as_mode);
  endfunction

  function automatic logic [CAR_BITS-1:0] pick(input src_cls_e cls,
                                               input logic [CAR_BITS-1:0] t_reg,
                                               input logic [CAR_BITS-1:0] t_ind,
                                               input logic [CAR_BITS-1:0] t_idx);
    case (cls)
      ClsReg:  return t_reg;
      ClsIdx:  return t_idx;
      default: return t_ind;
    endcase
  endfunction

  function automatic logic is_fetch_state(input logic [CAR_BITS-1:0] car);
    case (car)
      CAR_0, CAR_REG_REG, CAR_REG_IDX3, CAR_IND_REG1, CAR_IND_IDX4, CAR_IDX_REG2, CAR_IDX_IDX5,
      CAR_1OP_REG, CAR_1OP_IND2, CAR_1OP_IDX3, CAR_PUSH_REG2, CAR_PUSH_IND2,
      CAR_PUSH_IDX3: return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic is_terminal_state(input logic [CAR_BITS-1:0] car);
    case (car)
      CAR_CALL_REG2, CAR_CALL_IND2, CAR_CALL_IDX3, CAR_RETI3, CAR_JMP0,
      CAR_INT4: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/car_dispatch.sv
// Combinational instruction decoder: maps a fetched word to its first microstep.
// Undecodable words return CAR_0 with the illegal flag set so they retire as a NOP.
module car_dispatch
  import car_pkg::*;
(
  input  logic [15:0]         word,
  output logic [CAR_BITS-1:0] target,
  output logic                illegal
);

  src_cls_e f1_cls;
  src_cls_e f2_cls;
  src_cls_e raw_cls;
  logic     unused_bw;

  // Byte/word select does not influence the microsequence.
  assign unused_bw = word[6];

  always_comb begin
    target  = CAR_0;
    illegal = 1'b0;
    f1_cls  = src_class(word[11:8], word[5:4]);
    f2_cls  = src_class(word[3:0], word[5:4]);
    raw_cls = as_class(word[5:4]);

    if (word[15:12] >= 4'd4) begin
      if (word[7]) target = pick(f1_cls, CAR_REG_IDX0, CAR_IND_IDX0, CAR_IDX_IDX0);
      else         target = pick(f1_cls, CAR_REG_REG, CAR_IND_REG0, CAR_IDX_REG0);
    end else if (word[15:10] == F2_PREFIX) begin
      case (word[9:7])
        OP_PUSH: target = pick(raw_cls, CAR_PUSH_REG0, CAR_PUSH_IND0, CAR_PUSH_IDX0);
        OP_CALL: target = pick(raw_cls, CAR_CALL_REG0, CAR_CALL_IND0, CAR_CALL_IDX0);
        OP_RETI: target = CAR_RETI0;
        3'b111:  illegal = 1'b1;
        default: target = pick(f2_cls, CAR_1OP_REG, CAR_1OP_IND0, CAR_1OP_IDX0);
      endcase
    end else if (word[15:13] == JMP_PREFIX) begin
      target = CAR_JMP0;
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/car_sequencer.sv
// MSP430 microsequencer: owns CAR and IR, dispatches at fetch states and inserts
// the interrupt entry sequence at instruction boundaries.
module car_sequencer #(
  parameter int unsigned CAR_BITS = car_pkg::CAR_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         MDB_in,
  input  logic                Stall,
  input  logic                IRQ,
  input  logic                INTACK,
  output logic [CAR_BITS-1:0] CAR,
  output logic [15:0]         IR,
  output logic                Fetch,
  output logic                FetchSuppress,
  output logic                IllegalOp
);
  import car_pkg::*;

  logic [CAR_BITS-1:0] car_q, car_d;
  logic [15:0]         ir_q, ir_d;
  logic [CAR_BITS-1:0] disp_target;
  logic                disp_illegal;
  logic                unused_intack;

  assign unused_intack = INTACK;

  car_dispatch u_dispatch (
    .word    (MDB_in),
    .target  (disp_target),
    .illegal (disp_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_q <= CAR_0;
      ir_q  <= 16'h0000;
    end else begin
      car_q <= car_d;
      ir_q  <= ir_d;
    end
  end

  always_comb begin
    car_d         = car_q;
    ir_d          = ir_q;
    Fetch         = 1'b0;
    FetchSuppress = 1'b0;
    IllegalOp     = 1'b0;
    if (!Stall) begin
      if (car_q > CAR_LAST) begin
        car_d = CAR_0;
      end else if (is_fetch_state(car_q)) begin
        Fetch = 1'b1;
        if (IRQ) begin
          car_d         = CAR_INT0;
          FetchSuppress = 1'b1;
        end else begin
          ir_d      = MDB_in;
          car_d     = disp_target;
          // Reset gating keeps the pulse quiet while CAR_0 is held in reset.
          IllegalOp = disp_illegal & rst_n;
        end
      end else if (is_terminal_state(car_q)) begin
        car_d = CAR_0;
      end else begin
        car_d = car_q + 1'b1;
      end
    end
  end

  assign CAR = car_q;
  assign IR  = ir_q;

endmodule

// File: tb/tb_car_sequencer.sv
// Directed bench for car_sequencer: dispatch targets, microsequence walks, interrupt entry,
// stall and asynchronous reset, all against hand-computed CAR values.
module tb_car_sequencer;
  import car_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] mdb;
  logic        stall;
  logic        irq;
  logic        intack;
  logic [5:0]  car;
  logic [15:0] ir;
  logic        fetch;
  logic        fetch_suppress;
  logic        illegal_op;

  int n_checks = 0;
  int n_errors = 0;

  car_sequencer #(.CAR_BITS(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .MDB_in        (mdb),
    .Stall         (stall),
    .IRQ           (irq),
    .INTACK        (intack),
    .CAR           (car),
    .IR            (ir),
    .Fetch         (fetch),
    .FetchSuppress (fetch_suppress),
    .IllegalOp     (illegal_op)
  );

  assign intack = (car == CAR_INT4);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_car(input string tag, input logic [5:0] exp);
    tick();
    check(tag, {10'd0, car}, {10'd0, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    mdb   = 16'h0000;
    stall = 1'b0;
    irq   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_car", {10'd0, car}, 16'd0);
    check("rst_ir", ir, 16'h0000);
    check("rst_illegal", {15'd0, illegal_op}, 16'd0);

    // MOV R4,R5
    rst_n = 1'b1;
    mdb   = 16'h4405;
    #1;
    check("fetch_car0", {15'd0, fetch}, 16'd1);
    step_car("mov_rr", CAR_REG_REG);
    check("mov_rr_ir", ir, 16'h4405);
    check("fetch_regreg", {15'd0, fetch}, 16'd1);

    // MOV @R4,0(R5)
    mdb = 16'h44A5;
    step_car("ind_idx0", CAR_IND_IDX0);
    check("ind_idx_ir", ir, 16'h44A5);
    mdb = 16'hFFFF;
    #1;
    check("nofetch_ind_idx0", {15'd0, fetch}, 16'd0);
    step_car("ind_idx1", CAR_IND_IDX1);
    step_car("ind_idx2", CAR_IND_IDX2);
    step_car("ind_idx3", CAR_IND_IDX3);
    step_car("ind_idx4", CAR_IND_IDX4);
    check("ind_idx4_ir", ir, 16'h44A5);
    check("fetch_ind_idx4", {15'd0, fetch}, 16'd1);

    // Constant generator #1 and absolute mode
    mdb = 16'h4315;
    step_car("cg_r3", CAR_REG_REG);
    mdb = 16'h4215;
    step_car("abs_idx_reg0", CAR_IDX_REG0);
    step_car("abs_idx_reg1", CAR_IDX_REG1);
    step_car("abs_idx_reg2", CAR_IDX_REG2);

    // PUSH R4, RETI, JMP, CALL @R4
    mdb = 16'h1204;
    step_car("push0", CAR_PUSH_REG0);
    step_car("push1", CAR_PUSH_REG1);
    step_car("push2", CAR_PUSH_REG2);
    mdb = 16'h1300;
    step_car("reti0", CAR_RETI0);
    step_car("reti1", CAR_RETI1);
    step_car("reti2", CAR_RETI2);
    step_car("reti3", CAR_RETI3);
    step_car("reti_end", CAR_0);
    mdb = 16'h3C00;
    step_car("jmp0", CAR_JMP0);
    step_car("jmp_end", CAR_0);
    mdb = 16'h12A4;
    step_car("call_ind0", CAR_CALL_IND0);
    step_car("call_ind1", CAR_CALL_IND1);
    step_car("call_ind2", CAR_CALL_IND2);
    step_car("call_end", CAR_0);

    // Interrupt entry at a fetch boundary
    mdb = 16'h4405;
    step_car("pre_irq", CAR_REG_REG);
    irq = 1'b1;
    mdb = 16'h1204;
    #1;
    check("irq_suppress", {15'd0, fetch_suppress}, 16'd1);
    step_car("int0", CAR_INT0);
    check("irq_ir_kept", ir, 16'h4405);
    check("int0_nosuppress", {15'd0, fetch_suppress}, 16'd0);
    irq = 1'b0;
    step_car("int1", CAR_INT1);
    irq = 1'b1;
    step_car("int2", CAR_INT2);
    irq = 1'b0;
    step_car("int3", CAR_INT3);
    irq = 1'b1;
    step_car("int4", CAR_INT4);
    step_car("int_end", CAR_0);
    #1;
    check("irq_again_suppress", {15'd0, fetch_suppress}, 16'd1);
    step_car("int0_again", CAR_INT0);
    irq = 1'b0;
    step_car("int1_b", CAR_INT1);
    step_car("int2_b", CAR_INT2);
    step_car("int3_b", CAR_INT3);
    step_car("int4_b", CAR_INT4);
    step_car("int_end_b", CAR_0);
    check("int_ir_kept", ir, 16'h4405);

    // Stall in a fetch state beats IRQ and illegal dispatch
    mdb   = 16'h0000;
    irq   = 1'b1;
    stall = 1'b1;
    #1;
    check("stall_fetch", {15'd0, fetch}, 16'd0);
    check("stall_suppress", {15'd0, fetch_suppress}, 16'd0);
    check("stall_illegal", {15'd0, illegal_op}, 16'd0);
    step_car("stall_hold_car0", CAR_0);
    check("stall_ir", ir, 16'h4405);

    // Illegal words
    irq   = 1'b0;
    stall = 1'b0;
    #1;
    check("illegal_0000", {15'd0, illegal_op}, 16'd1);
    step_car("illegal_car", CAR_0);
    check("illegal_ir", ir, 16'h0000);
    mdb = 16'h1380;
    #1;
    check("illegal_f2_111", {15'd0, illegal_op}, 16'd1);
    step_car("illegal_f2_car", CAR_0);
    check("illegal_f2_ir", ir, 16'h1380);
    mdb = 16'h4405;
    #1;
    check("legal_no_pulse", {15'd0, illegal_op}, 16'd0);

    // MOV 2(R4),0(R5) with a 3-cycle stall in IDX_IDX2
    mdb = 16'h4495;
    step_car("idx_idx0", CAR_IDX_IDX0);
    step_car("idx_idx1", CAR_IDX_IDX1);
    step_car("idx_idx2", CAR_IDX_IDX2);
    stall = 1'b1;
    step_car("stall1", CAR_IDX_IDX2);
    step_car("stall2", CAR_IDX_IDX2);
    step_car("stall3", CAR_IDX_IDX2);
    stall = 1'b0;
    step_car("idx_idx3", CAR_IDX_IDX3);
    check("idx_idx3_ir", ir, 16'h4495);

    // Asynchronous reset mid-sequence
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_car", {10'd0, car}, 16'd0);
    check("async_rst_ir", ir, 16'h0000);
    tick();
    check("rst_hold_car", {10'd0, car}, 16'd0);
    rst_n = 1'b1;
    mdb   = 16'h4405;
    step_car("post_rst", CAR_REG_REG);
    check("post_rst_ir", ir, 16'h4405);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
